// File: rtl/hdmi_timing_pkg.sv
// Raster timing presets and shared types for the HDMI timing path.
// Latency: none (types and constants only). Backpressure: not applicable.
package hdmi_timing_pkg;

  localparam int COORD_W = 12;

  typedef struct packed {
    logic [COORD_W-1:0] h_active;
    logic [COORD_W-1:0] h_fp;
    logic [COORD_W-1:0] h_sync;
    logic [COORD_W-1:0] h_bp;
    logic [COORD_W-1:0] v_active;
    logic [COORD_W-1:0] v_fp;
    logic [COORD_W-1:0] v_sync;
    logic [COORD_W-1:0] v_bp;
  } timing_t;

  localparam timing_t TIMING_640X480_60 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96,  h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,   v_bp: 12'd33
  };

  localparam timing_t TIMING_1280X720_60 = '{
    h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
    v_active: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,  v_bp: 12'd20
  };

  // Bundle delayed through the colour-stage alignment line; hsync is the MSB.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  function automatic int h_total(input timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(input timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/hdmi_sync_delay.sv
// Fixed-depth shift register aligning sync/enable bits with the colour-stage output.
// Latency: DEPTH cycles (DEPTH=0 is a wire). Backpressure: none, shifts every cycle.
module hdmi_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing generator: pixel coordinates, frame pulse/counter, frame-stable channel, delayed syncs.
// Latency: coordinates 1 cycle after the counters; *_d a further DELAY cycles. Backpressure: none.
module hdmi_video_timing
  import hdmi_timing_pkg::*;
#(
  parameter int   H_ACTIVE = int'(TIMING_640X480_60.h_active),
  parameter int   H_FP     = int'(TIMING_640X480_60.h_fp),
  parameter int   H_SYNC   = int'(TIMING_640X480_60.h_sync),
  parameter int   H_BP     = int'(TIMING_640X480_60.h_bp),
  parameter int   V_ACTIVE = int'(TIMING_640X480_60.v_active),
  parameter int   V_FP     = int'(TIMING_640X480_60.v_fp),
  parameter int   V_SYNC   = int'(TIMING_640X480_60.v_sync),
  parameter int   V_BP     = int'(TIMING_640X480_60.v_bp),
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   DELAY    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         channel_sel_in,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               data_en,
  output logic [1:0]         channel_select,
  output logic               frame_start,
  output logic [7:0]         frame_cnt,
  output logic               hsync_d,
  output logic               vsync_d,
  output logic               de_d
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0};

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0] px_x_q, px_x_d;
  logic [COORD_W-1:0] px_y_q, px_y_d;
  sync_t              sync_q, sync_d;
  logic               frame_start_q, frame_start_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [1:0]         channel_q, channel_d;
  logic               started_q, started_d;
  logic               at_origin;
  sync_t              sync_dly;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end

    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    px_x_d       = h_cnt_q;
    px_y_d       = v_cnt_q;
    sync_d.de    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    sync_d.hsync = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    // Decoded from v alone, so vsync moves together with px_y on the h=0 edge.
    sync_d.vsync = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
    frame_start_d = at_origin;

    // The channel is sampled only at the top of a frame so one screen never mixes two sources.
    channel_d   = at_origin ? channel_sel_in : channel_q;
    started_d   = started_q | at_origin;
    frame_cnt_d = (at_origin && started_q) ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      sync_q        <= SYNC_IDLE;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      channel_q     <= '0;
      started_q     <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      sync_q        <= sync_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      channel_q     <= channel_d;
      started_q     <= started_d;
    end
  end

  hdmi_sync_delay #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_q),
    .dout  (sync_dly)
  );

  assign px_x           = px_x_q;
  assign px_y           = px_y_q;
  assign data_en        = sync_q.de;
  assign channel_select = channel_q;
  assign frame_start    = frame_start_q;
  assign frame_cnt      = frame_cnt_q;
  assign hsync_d        = sync_dly.hsync;
  assign vsync_d        = sync_dly.vsync;
  assign de_d           = sync_dly.de;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing on a reduced raster; expectations come from frame arithmetic on a cycle index.
module tb_hdmi_video_timing;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  channel_sel_in;
  logic [11:0] px_x, px_y;
  logic        data_en, frame_start, hsync_d, vsync_d, de_d;
  logic [1:0]  channel_select;
  logic [7:0]  frame_cnt;
  logic [11:0] z_px_x, z_px_y;
  logic        z_data_en, z_frame_start, z_hsync_d, z_vsync_d, z_de_d;
  logic [1:0]  z_channel_select;
  logic [7:0]  z_frame_cnt;

  int   vectors    = 0;
  int   miscompares = 0;
  int   n;
  int   last_fs;
  logic prev_hs, prev_vs, prev_de;
  logic [1:0] exp_ch;
  bit   rand_en;

  always #5 clk = ~clk;

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .DELAY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .channel_sel_in(channel_sel_in),
    .px_x(px_x), .px_y(px_y), .data_en(data_en),
    .channel_select(channel_select), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .hsync_d(hsync_d), .vsync_d(vsync_d), .de_d(de_d)
  );

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .DELAY(0)
  ) dut_nodly (
    .clk(clk), .rst_n(rst_n), .channel_sel_in(channel_sel_in),
    .px_x(z_px_x), .px_y(z_px_y), .data_en(z_data_en),
    .channel_select(z_channel_select), .frame_start(z_frame_start),
    .frame_cnt(z_frame_cnt), .hsync_d(z_hsync_d), .vsync_d(z_vsync_d), .de_d(z_de_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_px_x",        32'(px_x),           32'd0);
    chk("rst_px_y",        32'(px_y),           32'd0);
    chk("rst_data_en",     32'(data_en),        32'd0);
    chk("rst_frame_start", 32'(frame_start),    32'd0);
    chk("rst_frame_cnt",   32'(frame_cnt),      32'd0);
    chk("rst_channel",     32'(channel_select), 32'd0);
    chk("rst_hsync_d",     32'(hsync_d),        32'd1);
    chk("rst_vsync_d",     32'(vsync_d),        32'd1);
    chk("rst_de_d",        32'(de_d),           32'd0);
    chk("rst_hsync_d0",    32'(z_hsync_d),      32'd1);
    chk("rst_vsync_d0",    32'(z_vsync_d),      32'd1);
    chk("rst_de_d0",       32'(z_de_d),         32'd0);
  endtask

  task automatic model_restart();
    n       = 0;
    last_fs = -1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    prev_de = 1'b0;
    exp_ch  = 2'd0;
  endtask

  // n counts clock edges since reset release; raster position is n-1 modulo the frame.
  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      int   p, x, y, f;
      logic ehs, evs, ede;
      @(negedge clk);
      n++;
      p   = (n - 1) % FT;
      x   = p % HT;
      y   = p / HT;
      f   = (n - 1) / FT;
      ede = (x < HA) && (y < VA);
      ehs = (x >= HA + HFP && x < HA + HFP + HS) ? 1'b0 : 1'b1;
      evs = (y >= VA + VFP && y < VA + VFP + VS) ? 1'b0 : 1'b1;
      if (p == 0) exp_ch = channel_sel_in;

      chk("px_x",        32'(px_x),           32'(x));
      chk("px_y",        32'(px_y),           32'(y));
      chk("data_en",     32'(data_en),        32'(ede));
      chk("frame_start", 32'(frame_start),    32'(p == 0));
      chk("frame_cnt",   32'(frame_cnt),      32'(f % 256));
      chk("channel",     32'(channel_select), 32'(exp_ch));
      chk("hsync_d",     32'(hsync_d),        32'(prev_hs));
      chk("vsync_d",     32'(vsync_d),        32'(prev_vs));
      chk("de_d",        32'(de_d),           32'(prev_de));
      chk("hsync_d0",    32'(z_hsync_d),      32'(ehs));
      chk("vsync_d0",    32'(z_vsync_d),      32'(evs));
      chk("de_d0",       32'(z_de_d),         32'(ede));
      if (frame_start) begin
        if (last_fs >= 0) chk("fs_period", 32'(n - last_fs), 32'(FT));
        last_fs = n;
      end
      prev_hs = ehs;
      prev_vs = evs;
      prev_de = ede;

      // Mid-frame change in frame 0 must not reach channel_select before frame 1.
      if (!rand_en && f == 0 && y == VA / 2 && x == 0) channel_sel_in = 2'd2;
      if (f >= 1) rand_en = 1'b1;
      if (rand_en && $urandom_range(7) == 0) channel_sel_in = 2'($urandom_range(3));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    channel_sel_in = 2'd0;
    rand_en        = 1'b0;
    model_restart();

    repeat (5) begin
      @(negedge clk);
      chk_reset();
    end
    rst_n = 1'b1;

    // Run into frame 3 up to px=(6,4), then reset asynchronously between edges.
    run(3 * FT + 4 * HT + 6 + 1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (2) begin
      @(negedge clk);
      chk_reset();
    end
    rst_n = 1'b1;
    model_restart();

    // Long enough for frame_cnt to pass 255 and wrap to 0.
    run(258 * FT + 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
